// File: rtl/mutex_pkg.sv
// Shared definitions for the filter-lock mutual-exclusion model:
// program-counter encodings and packed-vector slice arithmetic.
package mutex_pkg;

  localparam logic [2:0] NCS  = 3'd0;
  localparam logic [2:0] SETL = 3'd1;
  localparam logic [2:0] SETV = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] CS   = 3'd4;
  localparam logic [2:0] EXIT = 3'd5;

  // Low bit of element idx inside a packed vector of width-bit elements.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/filter_wait_check.sv
// Filter-lock wait predicate: the stepping process is blocked while some other
// process publishes a level at least as high and it is still the victim there.
module filter_wait_check
  import mutex_pkg::*;
#(
  parameter int N = 3,
  parameter int W = $clog2(N)
) (
  input  logic [W*N-1:0] level,
  input  logic [W-1:0]   victim_cur,
  input  logic [W-1:0]   sel,
  input  logic [W-1:0]   cur_sel,
  output logic           blocked
);

  logic contender;

  always_comb begin
    contender = 1'b0;
    for (int k = 0; k < N; k++) begin
      if ((W'(k) != sel) && (level[slice_lo(k, W) +: W] >= cur_sel)) begin
        contender = 1'b1;
      end
    end
  end

  assign blocked = contender && (victim_cur == sel);

endmodule

// File: rtl/filter_mutex.sv
// N-process Peterson filter lock; one process, chosen by select, takes one
// action per clock. prop reports that at most one process is in CS.
module filter_mutex
  import mutex_pkg::*;
#(
  parameter int N = 3,
  localparam int W = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [W-1:0]   select,
  input  logic           pause,
  output logic [3*N-1:0] pc_o,
  output logic [W*N-1:0] level_o,
  output logic [N-1:0]   cs_mask,
  output logic           prop
);

  logic [2:0]   pc     [N];
  logic [W-1:0] level  [N];
  logic [W-1:0] cur    [N];
  logic [W-1:0] victim [N];

  logic         sel_valid;
  logic [W-1:0] sel_idx;
  logic [2:0]   sel_pc;
  logic [W-1:0] sel_cur;
  logic [W-1:0] sel_victim;
  logic         blocked;

  logic [2:0]   pc_nxt;
  logic [W-1:0] level_nxt;
  logic [W-1:0] cur_nxt;
  logic         victim_we;
  logic [4:0]   cs_count;

  // Out-of-range selects are clamped for indexing and masked from every write.
  assign sel_valid  = (int'(select) < N);
  assign sel_idx    = sel_valid ? select : '0;
  assign sel_pc     = pc[sel_idx];
  assign sel_cur    = cur[sel_idx];
  assign sel_victim = victim[sel_cur];

  filter_wait_check #(.N(N), .W(W)) u_wait_check (
    .level      (level_o),
    .victim_cur (sel_victim),
    .sel        (sel_idx),
    .cur_sel    (sel_cur),
    .blocked    (blocked)
  );

  always_comb begin
    pc_nxt    = sel_pc;
    level_nxt = level[sel_idx];
    cur_nxt   = sel_cur;
    victim_we = 1'b0;
    case (sel_pc)
      NCS: begin
        if (!pause) begin
          cur_nxt = W'(1);
          pc_nxt  = SETL;
        end
      end
      SETL: begin
        level_nxt = sel_cur;
        pc_nxt    = SETV;
      end
      SETV: begin
        victim_we = 1'b1;
        pc_nxt    = WAIT;
      end
      WAIT: begin
        if (!blocked) begin
          if (sel_cur == W'(N - 1)) begin
            pc_nxt = CS;
          end else begin
            cur_nxt = sel_cur + W'(1);
            pc_nxt  = SETL;
          end
        end
      end
      CS: begin
        if (!pause) begin
          pc_nxt = EXIT;
        end
      end
      EXIT: begin
        level_nxt = '0;
        cur_nxt   = '0;
        pc_nxt    = NCS;
      end
      default: pc_nxt = NCS;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        pc[i]     <= NCS;
        level[i]  <= '0;
        cur[i]    <= '0;
        victim[i] <= '0;
      end
    end else if (sel_valid) begin
      pc[sel_idx]    <= pc_nxt;
      level[sel_idx] <= level_nxt;
      cur[sel_idx]   <= cur_nxt;
      if (victim_we) begin
        victim[sel_cur] <= sel_idx;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_out
    assign pc_o[slice_lo(i, 3) +: 3]    = pc[i];
    assign level_o[slice_lo(i, W) +: W] = level[i];
    assign cs_mask[i]                   = (pc[i] == CS);
  end

  always_comb begin
    cs_count = '0;
    for (int i = 0; i < N; i++) begin
      cs_count = cs_count + 5'(cs_mask[i]);
    end
  end

  assign prop = (cs_count <= 5'd1);

  a_mutex: assert property (@(posedge clock) disable iff (reset) prop);

endmodule

// File: tb/tb_filter_mutex.sv
// Bench for filter_mutex: directed scenarios and random stress on N=3 against a
// reference model via a scoreboard, plus safety/liveness stress on N=2 and N=4.
module tb_filter_mutex;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [0:0] sel2;   logic pause2;
  logic [1:0] sel3;   logic pause3;
  logic [1:0] sel4;   logic pause4;

  logic [5:0]  pc2;  logic [1:0] lvl2; logic [1:0] cs2; logic prop2;
  logic [8:0]  pc3;  logic [5:0] lvl3; logic [2:0] cs3; logic prop3;
  logic [11:0] pc4;  logic [7:0] lvl4; logic [3:0] cs4; logic prop4;

  filter_mutex #(.N(2)) u2 (.clock(clock), .reset(reset), .select(sel2), .pause(pause2),
                            .pc_o(pc2), .level_o(lvl2), .cs_mask(cs2), .prop(prop2));
  filter_mutex #(.N(3)) u3 (.clock(clock), .reset(reset), .select(sel3), .pause(pause3),
                            .pc_o(pc3), .level_o(lvl3), .cs_mask(cs3), .prop(prop3));
  filter_mutex #(.N(4)) u4 (.clock(clock), .reset(reset), .select(sel4), .pause(pause4),
                            .pc_o(pc4), .level_o(lvl4), .cs_mask(cs4), .prop(prop4));

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the N=3 instance.
  int m_pc[3], m_lvl[3], m_cur[3], m_vic[3];

  typedef struct {
    logic [8:0] pc;
    logic [5:0] lvl;
    logic [2:0] cs;
    logic       prop;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pc[i] = 0; m_lvl[i] = 0; m_cur[i] = 0; m_vic[i] = 0;
    end
  endtask

  task automatic model_step(input int s, input bit p);
    int c;
    bit blk;
    if (s >= 3) return;
    c = m_cur[s];
    case (m_pc[s])
      0: if (!p) begin m_cur[s] = 1; m_pc[s] = 1; end
      1: begin m_lvl[s] = c; m_pc[s] = 2; end
      2: begin m_vic[c] = s; m_pc[s] = 3; end
      3: begin
        blk = 1'b0;
        for (int k = 0; k < 3; k++)
          if (k != s && m_lvl[k] >= c && m_vic[c] == s) blk = 1'b1;
        if (!blk) begin
          if (c == 2) m_pc[s] = 4;
          else begin m_cur[s] = c + 1; m_pc[s] = 1; end
        end
      end
      4: if (!p) m_pc[s] = 5;
      5: begin m_lvl[s] = 0; m_cur[s] = 0; m_pc[s] = 0; end
      default: m_pc[s] = 0;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int n;
    e.pc = '0; e.lvl = '0; e.cs = '0; n = 0;
    for (int i = 0; i < 3; i++) begin
      e.pc[3*i +: 3]  = 3'(m_pc[i]);
      e.lvl[2*i +: 2] = 2'(m_lvl[i]);
      e.cs[i]         = (m_pc[i] == 4);
      if (m_pc[i] == 4) n++;
    end
    e.prop = (n <= 1);
    return e;
  endfunction

  // One step of the N=3 instance, scoreboarded against the model.
  task automatic step(input int s, input bit p);
    exp_t e;
    sel3 = 2'(s);
    pause3 = p;
    model_step(s, p);
    sb.push_back(model_out());
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("sb_pc", pc3, e.pc);
    chk("sb_level", lvl3, e.lvl);
    chk("sb_cs", cs3, e.cs);
    chk("sb_prop", prop3, e.prop);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  bit stress_on = 1'b0;
  logic [1:0] seen2 = '0;
  logic [2:0] seen3 = '0;
  logic [3:0] seen4 = '0;

  always @(negedge clock) begin
    if (stress_on && !reset) begin
      chk("prop_n2", prop2, 1'b1);
      chk("prop_n3", prop3, 1'b1);
      chk("prop_n4", prop4, 1'b1);
      seen2 = seen2 | cs2;
      seen3 = seen3 | cs3;
      seen4 = seen4 | cs4;
    end
  end

  initial begin
    sel2 = '0; pause2 = 1'b1;
    sel3 = '0; pause3 = 1'b0;
    sel4 = '0; pause4 = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_pc", pc3, 9'd0);
    chk("rst_level", lvl3, 6'd0);
    chk("rst_cs", cs3, 3'd0);
    chk("rst_prop", prop3, 1'b1);

    // Solo entry: CS after 7 steps, EXIT at 8, NCS at 9
    for (int i = 0; i < 7; i++) step(0, 1'b0);
    chk("solo_pc_cs", pc3[2:0], 3'd4);
    chk("solo_level2", lvl3[1:0], 2'd2);
    chk("solo_mask", cs3, 3'b001);
    step(0, 1'b0);
    chk("solo_exit", pc3[2:0], 3'd5);
    step(0, 1'b0);
    chk("solo_ncs", pc3[2:0], 3'd0);
    chk("solo_level0", lvl3[1:0], 2'd0);

    // Contention at level 1
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1'b0);
    chk("cont_p0_wait", pc3[2:0], 3'd3);
    chk("cont_p0_lvl", lvl3[1:0], 2'd1);
    for (int i = 0; i < 3; i++) step(1, 1'b0);
    chk("cont_p1_wait", pc3[5:3], 3'd3);
    step(0, 1'b0);
    chk("cont_p0_pass", pc3[2:0], 3'd1);
    step(1, 1'b0);
    chk("cont_p1_block", pc3[5:3], 3'd3);
    step(0, 1'b0);
    chk("cont_p0_lvl2", lvl3[1:0], 2'd2);

    // Pause in NCS and CS
    do_reset();
    step(0, 1'b1);
    chk("pause_ncs", pc3[2:0], 3'd0);
    for (int i = 0; i < 7; i++) step(0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b1);
      chk("pause_cs_pc", pc3[2:0], 3'd4);
      chk("pause_cs_mask", cs3, 3'b001);
    end

    // Out-of-range select holds everything
    for (int i = 0; i < 4; i++) begin
      step(3, i[0]);
      chk("oor_pc", pc3, 9'd4);
      chk("oor_level", lvl3, 6'd2);
    end

    // Async reset while in CS
    reset = 1'b1;
    #2;
    chk("async_rst_pc", pc3, 9'd0);
    chk("async_rst_level", lvl3, 6'd0);
    chk("async_rst_cs", cs3, 3'd0);
    do_reset();

    // Random stress on all three sizes
    stress_on = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc % 1000 == 999) begin
        stress_on = 1'b0;
        do_reset();
        stress_on = 1'b1;
      end else begin
        sel2 = 1'($urandom_range(0, 1));
        pause2 = ($urandom_range(0, 3) == 0);
        sel4 = 2'($urandom_range(0, 3));
        pause4 = ($urandom_range(0, 3) == 0);
        step($urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      end
    end
    stress_on = 1'b0;
    chk("cs_seen_n2", seen2, 2'b11);
    chk("cs_seen_n3", seen3, 3'b111);
    chk("cs_seen_n4", seen4, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/filter_mutex.md
# filter_mutex

Parametrised N-process mutual-exclusion model using Peterson's filter lock. It generalises the two-process Dekker benchmark to any process count N ≥ 2. One process is stepped per clock, chosen by the `select` input. `pause` stalls a process in its noncritical and critical sections. The block is a model-checking benchmark: its safety property `prop` (at most one process in the critical section) is asserted inside the module.

## Interface
- `N`, default 3: number of processes; legal range 2..16.
- `W`, default `$clog2(N)`: width of process indices and levels (derived, not overridden).
- `clock  in  1`: single clock; all state updates on the rising edge.
- `reset  in  1`: asynchronous, active-high; returns all state to reset values immediately.
- `select  in  W`: index of the process stepped this cycle; values ≥ N step nothing.
- `pause  in  1`: when 1, a process in NCS or CS does not advance.
- `pc_o  out  3*N`: packed per-process program counter, process i at bits [3i+2:3i].
- `level_o  out  W*N`: packed per-process published level.
- `cs_mask  out  N`: bit i set when process i is in CS.
- `prop  out  1`: 1 when popcount(`cs_mask`) ≤ 1.

## Operation
- State per process i:
  - `pc[i]`, 3 bits.
  - `level[i]`, W bits: the published level.
  - `cur[i]`, W bits: the level currently being acquired.
- Shared state: `victim[l]`, W bits, for l = 1..N-1.
- PC encodings: NCS=0, SETL=1, SETV=2, WAIT=3, CS=4, EXIT=5. Codes 6–7 are unreachable; if reached, the process goes to NCS on its next step.
- Each edge, only process s = `select` (when s < N) executes one action. All other process state and all other victim entries hold.
- Actions of process s:
  - NCS: if `!pause`, set `cur[s]`=1 and go to SETL; otherwise stay.
  - SETL: `level[s]` = `cur[s]`; go to SETV.
  - SETV: `victim[cur[s]]` = s; go to WAIT.
  - WAIT: block when there exists k ≠ s with `level[k]` ≥ `cur[s]` and `victim[cur[s]]` == s. The check is evaluated atomically in the stepping cycle.
    - If blocked: stay in WAIT.
    - If not blocked and `cur[s]` == N-1: go to CS.
    - If not blocked otherwise: `cur[s]` += 1, go to SETL.
  - CS: if `!pause`, go to EXIT; otherwise stay.
  - EXIT: `level[s]`=0, `cur[s]`=0; go to NCS.
- `level` and `cur` never exceed N-1. No wrap-around is possible.
- Internal assertion: `assert property (prop)`.

## Timing
- Reset values:
  - every `pc` = NCS, every `level` = 0, every `cur` = 0, every `victim` = 0.
  - Consequently `cs_mask`=0 and `prop`=1.
- Reset asserted mid-operation, including while a process is in CS, clears everything asynchronously. Release takes effect at the next edge.
- All outputs are combinational decodes of registers: zero added latency. A step is visible after the rising edge that performs it.
- Minimum entry: a solo process reaches CS after 3(N-1)+1 consecutive steps from NCS, with `pause`=0.
- `pause` affects only the stepped process and only in NCS or CS. In SETL, SETV, WAIT and EXIT, `pause` is ignored.

## Structure
- Shared package `mutex_pkg` holds:
  - the PC encodings NCS..EXIT as `localparam`s;
  - a function computing the packed-slice offsets.
- Sub-module `filter_wait_check` is combinational. Inputs: the level vector, the victim entry at `cur[s]`, s, and `cur[s]`. Output: `blocked`.
- The top holds the `pc`/`level`/`cur`/`victim` arrays, the per-process step decode, and the popcount for `prop`.

## Test plan
- Reset with N=3: after `reset` is released, `pc_o`=0, `level_o`=0, `cs_mask`=0, `prop`=1.
- Solo entry, N=3, `select`=0 held, `pause`=0:
  - after edge 7, `pc[0]`=CS with `level[0]`=2;
  - edge 8 puts it in EXIT;
  - edge 9 returns it to NCS with `level[0]`=0.
- Contention, N=3: step p0 three times (p0 in WAIT, `level`=1, `victim[1]`=0), then step p1 three times (`victim[1]`=1).
  - A p0 step now passes level 1: `cur[0]`=2, p0 in SETL.
  - A p1 step now stays in WAIT.
- Pause: with `pause`=1, p0 stepped in NCS stays in NCS. Bring p0 to CS and step it with `pause`=1 for 5 cycles: it stays in CS with `cs_mask`=3'b001.
- Out-of-range select, N=3: `select`=3 for 4 cycles leaves all registers unchanged.
- Random stress, N=2,3,4: random `select`/`pause` for 10k cycles, with reset pulses every ~1k cycles.
  - `prop` is never 0.
  - Every process enters CS at least once.
